reg_dump_reader: RTL and testbench

Debug read-out engine for the MIPS single-cycle core's 32×32 register file. On a start request it walks a contiguous range of register addresses through a dedicated combinational read port, captures each word, and streams it out over a valid/ready interface with its index. It sits between the register file's debug read port and the debug/trace host. It also requests a core stall while a dump is active so the snapshot is coherent.

---
 rtl/mips_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 128 ++++++++++++
 tb/tb_reg_dump_reader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-file geometry and the debug dump FSM states.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a register range through the register file's debug
// read port and streams each word out over valid/ready, stalling the core meanwhile.
module reg_dump_reader
    import mips_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [REG_ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0]     rf_data,
    output logic                  stall_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

    dump_state_t           state;
    dump_state_t           state_next;
    logic [REG_ADDR_W-1:0] idx;
    logic [REG_ADDR_W-1:0] idx_next;
    logic [DATA_W-1:0]     data_next;
    logic [REG_ADDR_W-1:0] index_next;
    logic                  last_next;
    logic                  valid_next;
    logic                  busy_next;
    logic                  done_next;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, walk counter and the next value of every registered output
    always_comb begin
        state_next = state;
        idx_next   = idx;
        data_next  = out_data;
        index_next = out_index;
        last_next  = out_last;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = FETCH;
                    idx_next   = FIRST_IDX;
                end
            end
            FETCH: begin
                state_next = SEND;
                data_next  = rf_data;
                index_next = idx;
                last_next  = (idx == LAST_IDX);
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_next = DONE;
                    end else begin
                        state_next = FETCH;
                        idx_next   = idx + REG_ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over handshake; only way out_valid may fall without a handshake
        if (state != IDLE && abort) begin
            state_next = IDLE;
        end

        if (state_next == IDLE) begin
            idx_next   = FIRST_IDX;
            data_next  = '0;
            index_next = '0;
            last_next  = 1'b0;
        end

        valid_next = (state_next == SEND);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx       <= FIRST_IDX;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            idx       <= idx_next;
            out_data  <= data_next;
            out_index <= index_next;
            out_last  <= last_next;
            out_valid <= valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    assign rf_addr   = idx;
    assign stall_req = busy;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: full-range and sub-range instances against
// a queue-based model of the expected word stream and dump timing.
module tb_reg_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, abort_a, ready_a;
    logic [4:0]  addr_a;
    logic [31:0] rdata_a;
    logic        stall_a, valid_a, last_a, busy_a, done_a;
    logic [31:0] data_a;
    logic [4:0]  index_a;

    logic        start_b, abort_b, ready_b;
    logic [4:0]  addr_b;
    logic [31:0] rdata_b;
    logic        stall_b, valid_b, last_b, busy_b, done_b;
    logic [31:0] data_b;
    logic [4:0]  index_b;

    logic [31:0] regs [32];

    assign rdata_a = regs[addr_a];
    assign rdata_b = regs[addr_b];

    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .rf_addr(addr_a), .rf_data(rdata_a), .stall_req(stall_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
        .out_index(index_a), .out_last(last_a), .busy(busy_a), .done(done_a)
    );

    reg_dump_reader #(.FIRST_REG(8), .LAST_REG(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .rf_addr(addr_b), .rf_data(rdata_b), .stall_req(stall_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .out_index(index_b), .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < 32; i++) begin
            regs[i] = rnd ? $urandom : (32'hA5A5_0000 + 32'(i));
        end
    endtask

    // Core write port model: the core only writes when not stalled
    task automatic core_write(input int a, input logic [31:0] v);
        if (!stall_a) regs[a] = v;
    endtask

    // mode 0: always ready; 1: hold ready low 5 cycles on index 3; 2: random ready,
    // stray start pulses and core write attempts. abort_at >= 0 aborts in SEND at that index.
    task automatic dump_a(input int mode, input int abort_at);
        logic [31:0] exp_q [$];
        int exp_idx = 0;
        int waits   = 0;
        int hold3   = 0;
        int t;
        bit finished = 1'b0;
        bit aborted  = 1'b0;
        for (int i = 0; i < 32; i++) exp_q.push_back(regs[i]);

        start_a = 1'b1; abort_a = 1'b0; ready_a = 1'b0;
        step();
        start_a = 1'b0;
        t = 1;
        check("busy_after_start", 32'(busy_a), 32'd1);
        check("valid_after_start", 32'(valid_a), 32'd0);

        while (!finished && t < 400) begin
            if (valid_a) begin
                check("word_index", 32'(index_a), 32'(exp_idx));
                check("word_data", data_a, exp_q[exp_idx]);
                check("word_last", 32'(last_a), 32'(exp_idx == 31));
                case (mode)
                    0: ready_a = 1'b1;
                    1: begin
                        ready_a = !(index_a == 5'd3 && hold3 < 5);
                        if (!ready_a) hold3++;
                    end
                    default: ready_a = ($urandom_range(0, 3) != 0);
                endcase
                if (abort_at == int'(index_a)) begin
                    abort_a  = 1'b1;
                    start_a  = 1'b0;
                    ready_a  = 1'($urandom_range(0, 1));
                    aborted  = 1'b1;
                    finished = 1'b1;
                end else if (ready_a) begin
                    exp_idx++;
                end else begin
                    waits++;
                end
            end else if (done_a) begin
                check("done_cycle", 32'(t), 32'(1 + 2 * 32 + waits));
                check("words_accepted", 32'(exp_idx), 32'd32);
                check("busy_in_done", 32'(busy_a), 32'd1);
                start_a  = 1'b0;
                finished = 1'b1;
            end else begin
                check("busy_in_fetch", 32'(busy_a), 32'd1);
                ready_a = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (mode == 2) begin
                core_write(5, $urandom);
                if (!finished) start_a = 1'($urandom_range(0, 1));
            end
            if (!finished) begin
                step();
                t++;
            end
        end
        if (!finished) check("dump_timeout", 32'd1, 32'd0);

        step();
        abort_a = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        check(aborted ? "abort_valid" : "idle_valid", 32'(valid_a), 32'd0);
        check(aborted ? "abort_busy" : "idle_busy", 32'(busy_a), 32'd0);
        check(aborted ? "abort_done" : "idle_done", 32'(done_a), 32'd0);
        check(aborted ? "abort_addr" : "idle_addr", 32'(addr_a), 32'd0);
    endtask

    initial begin
        int t;
        int cnt;
        bit found;

        rst = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
        preload(1'b0);
        repeat (3) step();

        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_stall", 32'(stall_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_last", 32'(last_a), 32'd0);
        check("rst_data", data_a, 32'd0);
        check("rst_index", 32'(index_a), 32'd0);
        check("rst_addr_a", 32'(addr_a), 32'd0);
        check("rst_addr_b", 32'(addr_b), 32'd8);
        rst = 1'b1;
        step();

        // Full dump, then an immediate restart under backpressure
        dump_a(0, -1);
        dump_a(1, -1);

        // Abort at index 12, then a fresh dump restarting at index 0
        preload(1'b1);
        dump_a(0, 12);
        dump_a(0, -1);

        // start and abort together in IDLE
        start_a = 1'b1; abort_a = 1'b1;
        step();
        check("start_abort_busy", 32'(busy_a), 32'd0);
        start_a = 1'b0; abort_a = 1'b0;
        step();
        check("start_abort_busy2", 32'(busy_a), 32'd0);

        // Reset during FETCH of index 20
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        ready_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (busy_a && !valid_a && !done_a && addr_a == 5'd20) found = 1'b1;
            else step();
        end
        check("reach_fetch_20", 32'(found), 32'd1);
        rst = 1'b0;
        step();
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_stall", 32'(stall_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_last", 32'(last_a), 32'd0);
        check("midrst_data", data_a, 32'd0);
        check("midrst_index", 32'(index_a), 32'd0);
        check("midrst_addr", 32'(addr_a), 32'd0);
        rst = 1'b1;
        ready_a = 1'b0;
        step();

        // Randomized contents, backpressure, stray starts and blocked core writes
        repeat (4) begin
            preload(1'b1);
            dump_a(2, -1);
        end

        // Sub-range instance: registers 8..10
        preload(1'b0);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        ready_b = 1'b1;
        t = 1;
        cnt = 0;
        found = 1'b0;
        while (!found && t < 40) begin
            if (valid_b) begin
                check("sub_index", 32'(index_b), 32'(8 + cnt));
                check("sub_data", data_b, 32'hA5A5_0000 + 32'(8 + cnt));
                check("sub_last", 32'(last_b), 32'(cnt == 2));
                cnt++;
            end
            if (done_b) begin
                check("sub_done_cycle", 32'(t), 32'd7);
                check("sub_word_count", 32'(cnt), 32'd3);
                found = 1'b1;
            end else begin
                step();
                t++;
            end
        end
        if (!found) check("sub_timeout", 32'd1, 32'd0);
        ready_b = 1'b0;
        step();
        check("sub_idle_busy", 32'(busy_b), 32'd0);
        check("sub_idle_addr", 32'(addr_b), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
